// File: rtl/trace_buffer_pkg.sv
// Shared types for the instruction trace buffer: FSM encodings, entry layout
// and default sizing.
package trace_buffer_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int ENTRY_W       = 98;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } traceState_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [31:0] aluResult;
        logic        regWrite;
        logic        memWrite;
    } traceEntry_t;

    function automatic traceEntry_t packEntry(input logic [31:0] pc,
                                              input logic [31:0] instruction,
                                              input logic [31:0] aluResult,
                                              input logic        regWrite,
                                              input logic        memWrite);
        traceEntry_t e;
        e.pc          = pc;
        e.instruction = instruction;
        e.aluResult   = aluResult;
        e.regWrite    = regWrite;
        e.memWrite    = memWrite;
        return e;
    endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Capture, control and readout signals of the trace buffer; the master side
// is the processor/debug host, the slave side is the buffer itself.
interface trace_buffer_if #(parameter int DEPTH = trace_buffer_pkg::DEFAULT_DEPTH);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   iPC;
    logic [31:0]   iInstruction;
    logic [31:0]   iAluResult;
    logic          iRegWrite;
    logic          iMemWrite;
    logic          iArm;
    logic          iClear;
    logic          iTrigEn;
    logic [31:0]   iTrigPC;
    logic [CW-1:0] iCapLen;
    logic          iReady;

    logic          oValid;
    logic [31:0]   oPC;
    logic [31:0]   oInstruction;
    logic [31:0]   oAluResult;
    logic [1:0]    oFlags;
    logic [CW-1:0] oCount;
    logic          oFull;
    logic          oEmpty;
    logic          oOverflow;
    logic [1:0]    oState;

    modport master (
        output iPC, iInstruction, iAluResult, iRegWrite, iMemWrite,
               iArm, iClear, iTrigEn, iTrigPC, iCapLen, iReady,
        input  oValid, oPC, oInstruction, oAluResult, oFlags,
               oCount, oFull, oEmpty, oOverflow, oState
    );

    modport slave (
        input  iPC, iInstruction, iAluResult, iRegWrite, iMemWrite,
               iArm, iClear, iTrigEn, iTrigPC, iCapLen, iReady,
        output oValid, oPC, oInstruction, oAluResult, oFlags,
               oCount, oFull, oEmpty, oOverflow, oState
    );

endinterface

// File: rtl/trace_buffer_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port so the
// head entry can fall through to the outputs without a read cycle.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 98
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/trace_buffer.sv
// Instruction trace buffer: arm/trigger FSM, circular pointers and occupancy
// around a trace_ram, with first-word fall-through readout.
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter bit WRAP  = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    trace_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    traceState_e state, stateNext;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count, sessCnt, sessNext, effCapLen;
    logic          overflow;
    logic          full, rdReq, capAttempt, wrEn, rdAdv, overflowSet, ramWe;
    traceEntry_t   wrEntry, head;
    logic [ENTRY_W-1:0] rdData;

    assign full      = (count == CW'(DEPTH));
    assign effCapLen = (bus.iCapLen == '0) ? CW'(DEPTH) : bus.iCapLen;
    assign wrEntry   = packEntry(bus.iPC, bus.iInstruction, bus.iAluResult,
                                 bus.iRegWrite, bus.iMemWrite);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A full buffer drops the record (and ends the session) only when nothing
    // is being read out in the same cycle; with WRAP it overwrites the head.
    always_comb begin
        stateNext   = state;
        sessNext    = sessCnt;
        capAttempt  = 1'b0;
        wrEn        = 1'b0;
        rdAdv       = 1'b0;
        overflowSet = 1'b0;
        rdReq       = (count != '0) && bus.iReady;

        if (bus.iArm) begin
            stateNext = bus.iTrigEn ? ARMED : CAPTURE;
            sessNext  = '0;
        end else begin
            case (state)
                ARMED:   capAttempt = (bus.iPC == bus.iTrigPC);
                CAPTURE: capAttempt = 1'b1;
                default: capAttempt = 1'b0;
            endcase
        end

        if (capAttempt) begin
            if (full && !WRAP && !rdReq) begin
                overflowSet = 1'b1;
                stateNext   = DONE;
            end else begin
                wrEn      = 1'b1;
                sessNext  = sessCnt + CW'(1);
                stateNext = (sessNext >= effCapLen) ? DONE : CAPTURE;
                if (full && !rdReq) begin
                    overflowSet = 1'b1;
                end
            end
        end

        rdAdv = rdReq || (wrEn && full);

        if (bus.iClear) begin
            stateNext   = IDLE;
            sessNext    = '0;
            wrEn        = 1'b0;
            rdAdv       = 1'b0;
            overflowSet = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            sessCnt  <= '0;
            overflow <= 1'b0;
        end else if (bus.iClear) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            sessCnt  <= '0;
            overflow <= 1'b0;
        end else begin
            sessCnt <= sessNext;
            if (wrEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (rdAdv) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (wrEn && !rdAdv) begin
                count <= count + CW'(1);
            end else if (!wrEn && rdAdv) begin
                count <= count - CW'(1);
            end
            if (overflowSet) begin
                overflow <= 1'b1;
            end
        end
    end

    // The RAM port is clocked independently of reset, so block any write on a reset edge.
    assign ramWe = wrEn && !reset;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) ram (
        .clock  (clock),
        .we     (ramWe),
        .wrAddr (wrPtr),
        .wrData (wrEntry),
        .rdAddr (rdPtr),
        .rdData (rdData)
    );

    assign head             = traceEntry_t'(rdData);
    assign bus.oPC          = head.pc;
    assign bus.oInstruction = head.instruction;
    assign bus.oAluResult   = head.aluResult;
    assign bus.oFlags       = {head.regWrite, head.memWrite};
    assign bus.oValid       = (count != '0);
    assign bus.oEmpty       = (count == '0);
    assign bus.oFull        = full;
    assign bus.oCount       = count;
    assign bus.oOverflow    = overflow;
    assign bus.oState       = state;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a stop-when-full and a wrapping instance
// see identical stimulus and are checked against hand-computed expectations.
module tb_trace_buffer;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    trace_buffer_if #(.DEPTH(16)) busN ();
    trace_buffer_if #(.DEPTH(16)) busW ();

    trace_buffer #(.DEPTH(16), .WRAP(1'b0)) dutN (.clock(clock), .reset(reset), .bus(busN.slave));
    trace_buffer #(.DEPTH(16), .WRAP(1'b1)) dutW (.clock(clock), .reset(reset), .bus(busW.slave));

    assign busW.iPC          = busN.iPC;
    assign busW.iInstruction = busN.iInstruction;
    assign busW.iAluResult   = busN.iAluResult;
    assign busW.iRegWrite    = busN.iRegWrite;
    assign busW.iMemWrite    = busN.iMemWrite;
    assign busW.iArm         = busN.iArm;
    assign busW.iClear       = busN.iClear;
    assign busW.iTrigEn      = busN.iTrigEn;
    assign busW.iTrigPC      = busN.iTrigPC;
    assign busW.iCapLen      = busN.iCapLen;
    assign busW.iReady       = busN.iReady;

    always #5 clock = ~clock;

    typedef struct {
        bit          clearFirst;
        bit          trigEn;
        logic [31:0] trigPC;
        logic [4:0]  capLen;
        bit          ready;
        logic [31:0] base;
        int          cycles;
        int          nCount;
        logic [1:0]  nState;
        bit          nOvf;
        logic [31:0] nHead;
        int          wCount;
        logic [1:0]  wState;
        bit          wOvf;
        logic [31:0] wHead;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Instruction, ALU result and flags are derived from the PC so every field of the head can be predicted.
    task automatic applyStimulus(input bit arm, input bit clear, input bit trigEn,
                                 input logic [31:0] trigPC, input logic [4:0] capLen,
                                 input bit ready, input logic [31:0] pc);
        busN.iArm         = arm;
        busN.iClear       = clear;
        busN.iTrigEn      = trigEn;
        busN.iTrigPC      = trigPC;
        busN.iCapLen      = capLen;
        busN.iReady       = ready;
        busN.iPC          = pc;
        busN.iInstruction = pc ^ 32'hA5A5_0000;
        busN.iAluResult   = pc + 32'h11;
        busN.iRegWrite    = pc[3];
        busN.iMemWrite    = pc[2];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic runVector(input vec_t v);
        if (v.clearFirst) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, v.trigEn, v.trigPC, v.capLen, v.ready, v.base);
        tick();
        for (int k = 1; k <= v.cycles; k++) begin
            applyStimulus(1'b0, 1'b0, v.trigEn, v.trigPC, v.capLen, v.ready, v.base + 32'(4 * k));
            tick();
        end
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d N count", i), 32'(busN.oCount), 32'(v.nCount));
        checkOutput($sformatf("v%0d N state", i), 32'(busN.oState), 32'(v.nState));
        checkOutput($sformatf("v%0d N overflow", i), 32'(busN.oOverflow), 32'(v.nOvf));
        checkOutput($sformatf("v%0d N full", i), 32'(busN.oFull), 32'(v.nCount == 16));
        checkOutput($sformatf("v%0d N empty", i), 32'(busN.oEmpty), 32'(v.nCount == 0));
        checkOutput($sformatf("v%0d N valid", i), 32'(busN.oValid), 32'(v.nCount != 0));
        if (v.nCount != 0) begin
            checkOutput($sformatf("v%0d N headPC", i), busN.oPC, v.nHead);
            checkOutput($sformatf("v%0d N headInstr", i), busN.oInstruction, v.nHead ^ 32'hA5A5_0000);
            checkOutput($sformatf("v%0d N headAlu", i), busN.oAluResult, v.nHead + 32'h11);
            checkOutput($sformatf("v%0d N headFlags", i), 32'(busN.oFlags), 32'(v.nHead[3:2]));
        end
        checkOutput($sformatf("v%0d W count", i), 32'(busW.oCount), 32'(v.wCount));
        checkOutput($sformatf("v%0d W state", i), 32'(busW.oState), 32'(v.wState));
        checkOutput($sformatf("v%0d W overflow", i), 32'(busW.oOverflow), 32'(v.wOvf));
        checkOutput($sformatf("v%0d W full", i), 32'(busW.oFull), 32'(v.wCount == 16));
        if (v.wCount != 0) begin
            checkOutput($sformatf("v%0d W headPC", i), busW.oPC, v.wHead);
        end
    endtask

    task automatic fillSeven(input logic [31:0] base);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, base);
        tick();
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, base + 32'(4 * k));
            tick();
        end
        checkOutput("fill7 count", 32'(busN.oCount), 32'd7);
        checkOutput("fill7 state", 32'(busN.oState), 32'(ST_CAPTURE));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0,        5'd4, 1'b0, 32'h0040_0000, 6,
                    4,  ST_DONE,  1'b0, 32'h0040_0004, 4,  ST_DONE,  1'b0, 32'h0040_0004};
        vecs[1] = '{1'b1, 1'b1, 32'h0040_0010, 5'd3, 1'b0, 32'h0040_0000, 8,
                    3,  ST_DONE,  1'b0, 32'h0040_0010, 3,  ST_DONE,  1'b0, 32'h0040_0010};
        vecs[2] = '{1'b1, 1'b0, 32'h0,        5'd2, 1'b0, 32'h0000_1000, 3,
                    2,  ST_DONE,  1'b0, 32'h0000_1004, 2,  ST_DONE,  1'b0, 32'h0000_1004};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 32'h0000_2000, 20,
                    16, ST_DONE,  1'b1, 32'h0000_1004, 16, ST_DONE,  1'b1, 32'h0000_2004};
        vecs[4] = '{1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 32'h0000_3000, 17,
                    16, ST_DONE,  1'b0, 32'h0000_3004, 16, ST_DONE,  1'b0, 32'h0000_3004};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        5'd4, 1'b0, 32'h0000_4000, 5,
                    16, ST_DONE,  1'b1, 32'h0000_3004, 16, ST_DONE,  1'b1, 32'h0000_3014};
        vecs[6] = '{1'b1, 1'b1, 32'hDEAD_0000, 5'd4, 1'b0, 32'h0000_7000, 6,
                    0,  ST_ARMED, 1'b0, 32'h0,         0,  ST_ARMED, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_8008, 5'd1, 1'b0, 32'h0000_8000, 4,
                    1,  ST_DONE,  1'b0, 32'h0000_8008, 1,  ST_DONE,  1'b0, 32'h0000_8008};

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        checkOutput("reset count", 32'(busN.oCount), 32'd0);
        checkOutput("reset state", 32'(busN.oState), 32'(ST_IDLE));
        checkOutput("reset empty", 32'(busN.oEmpty), 32'd1);
        checkOutput("reset full", 32'(busN.oFull), 32'd0);
        checkOutput("reset overflow", 32'(busN.oOverflow), 32'd0);
        checkOutput("reset valid", 32'(busN.oValid), 32'd0);
        checkOutput("reset W valid", 32'(busW.oValid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Consumer always ready: each record is at the head one edge after capture and leaves on the next.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5'd5, 1'b1, 32'h0000_5000);
        tick();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 1'b1, 32'h0000_5000 + 32'(4 * k));
            tick();
            checkOutput($sformatf("stream%0d count", k), 32'(busN.oCount), 32'd1);
            checkOutput($sformatf("stream%0d headPC", k), busN.oPC, 32'h0000_5000 + 32'(4 * k));
        end
        tick();
        checkOutput("stream drained count", 32'(busN.oCount), 32'd0);
        checkOutput("stream state", 32'(busN.oState), 32'(ST_DONE));
        checkOutput("stream overflow", 32'(busN.oOverflow), 32'd0);

        fillSeven(32'h0000_6000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0000_6020);
        tick();
        checkOutput("clear count", 32'(busN.oCount), 32'd0);
        checkOutput("clear state", 32'(busN.oState), 32'(ST_IDLE));
        checkOutput("clear valid", 32'(busN.oValid), 32'd0);
        checkOutput("clear W count", 32'(busW.oCount), 32'd0);

        fillSeven(32'h0000_9000);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset count", 32'(busN.oCount), 32'd0);
        checkOutput("async reset state", 32'(busN.oState), 32'(ST_IDLE));
        checkOutput("async reset valid", 32'(busN.oValid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("post reset count", 32'(busN.oCount), 32'd0);
        checkOutput("post reset state", 32'(busN.oState), 32'(ST_IDLE));
        checkOutput("post reset W count", 32'(busW.oCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; power of two, 4..256.
REQ-002 Parameter WRAP, default 0; 0 stops capture when full, 1 overwrites the oldest entry.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 iPC  in  32  processor PC of the current cycle.
REQ-006 iInstruction  in  32  instruction word being executed.
REQ-007 iAluResult  in  32  ALU result of the current cycle.
REQ-008 iRegWrite, iMemWrite  in  1 each  control flags of the current cycle.
REQ-009 iArm  in  1  one-cycle pulse that starts a capture session.
REQ-010 iClear  in  1  one-cycle pulse that flushes the buffer and returns to IDLE.
REQ-011 iTrigEn  in  1; iTrigPC  in  32  PC trigger enable and match value.
REQ-012 iCapLen  in  $clog2(DEPTH)+1  records per session; 0 means DEPTH.
REQ-013 iReady  in  1  readout consumer accepts the head entry.
REQ-014 oValid  out  1  head entry available (buffer not empty).
REQ-015 oPC, oInstruction, oAluResult  out  32 each  head-entry fields; oFlags  out  2  {RegWrite,MemWrite}.
REQ-016 oCount  out  $clog2(DEPTH)+1  entries held; oFull, oEmpty  out  1 each.
REQ-017 oOverflow  out  1  sticky; set when an entry was lost or overwritten.
REQ-018 oState  out  2  current FSM state, for debug.

Function
REQ-019 The FSM SHALL have the states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-020 On iArm in IDLE or DONE, the FSM SHALL go to ARMED if iTrigEn=1, else to CAPTURE; the session counter SHALL clear and buffer contents SHALL be kept.
REQ-021 In ARMED, when iPC==iTrigPC, the FSM SHALL write that cycle's record and go to CAPTURE.
REQ-022 In CAPTURE, exactly one record {iPC,iInstruction,iAluResult,iRegWrite,iMemWrite} SHALL be written per clock.
REQ-023 When the session counter reaches the effective iCapLen, the FSM SHALL go to DONE in the same edge as the final write.
REQ-024 With WRAP=0 and the buffer full, a capture attempt SHALL drop the record, set oOverflow and go to DONE.
REQ-025 With WRAP=1 and the buffer full, a capture SHALL overwrite the oldest entry, advance the read pointer, keep oCount=DEPTH and set oOverflow.
REQ-026 Readout SHALL be first-word fall-through: output fields show the head entry combinationally, and oValid = !oEmpty in every state.
REQ-027 A read SHALL occur when oValid and iReady are both high on a clock edge; the read pointer then advances by 1.
REQ-028 On a simultaneous write and read when not full, oCount SHALL be unchanged and both pointers SHALL advance.
REQ-029 On a simultaneous write and read when full, with WRAP=0 the write SHALL be accepted (no overflow); with WRAP=1 the read pointer SHALL advance only once.
REQ-030 Pointers SHALL wrap modulo DEPTH; oFull = (oCount==DEPTH), oEmpty = (oCount==0).
REQ-031 iClear SHALL take priority over iArm, writes and reads; it zeroes the pointers, oCount and oOverflow and sets the state to IDLE.
REQ-032 iArm in ARMED or CAPTURE SHALL restart the session counter and stay in CAPTURE or ARMED per iTrigEn.
REQ-033 Write latency SHALL be 1 clock: a record captured at edge N is visible at the head at N+1 if the buffer was empty.

Reset
REQ-034 Reset SHALL force state IDLE, pointers 0, oCount=0, oEmpty=1, oFull=0, oOverflow=0, oValid=0.
REQ-035 Storage contents SHALL NOT be reset; output fields are don't-care while oValid=0.
REQ-036 Reset asserted mid-session SHALL abort the session immediately; no write SHALL occur on the reset edge.

Structure
REQ-037 The shared params.v SHALL hold the FSM state encodings, the default DEPTH and the trace entry width (98).
REQ-038 Storage SHALL be a sub-module trace_ram: one synchronous write port and one asynchronous read port, DEPTH x 98 bits.
REQ-039 The FSM, pointers and counters SHALL live in trace_buffer; trace_buffer SHALL be instantiated beside the Datapath at top level and fed from its debug outputs.

Verification
REQ-040 Bench SHALL cover: iTrigEn=0, iCapLen=4, iArm, iReady=0 -> 4 entries with consecutive PCs, oCount=4, state DONE, oOverflow=0.
REQ-041 Bench SHALL cover: iTrigEn=1, iTrigPC=0x00400010, PC stepping by 4 from 0x00400000 -> first entry PC=0x00400010.
REQ-042 Bench SHALL cover: DEPTH=16, WRAP=0, iCapLen=0, iReady=0 for 20 cycles -> oFull=1, oOverflow=1, DONE, head PC = first captured PC.
REQ-043 Bench SHALL cover: WRAP=1, 20 captures -> oCount=16, head = 5th captured record, oOverflow=1.
REQ-044 Bench SHALL cover: iReady=1 throughout capture -> oCount stays at most 1, all records read in order, oOverflow=0.
REQ-045 Bench SHALL cover: reset, and separately iClear, asserted mid-CAPTURE with 7 entries held -> oCount=0, IDLE, oValid=0 on the next edge.
